qam_stream_packer: RTL and testbench

QAM_STREAM_PACKER -- requirements
Module: qam_stream_packer

---
 rtl/qam_stream_packer_if.sv | 23 ++
 rtl/qam_stream_packer.sv | 174 +++++++++++++++++
 tb/tb_qam_stream_packer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qam_stream_packer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qam_stream_packer_if : UART packet byte stream plus its ready line |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface qam_stream_packer_if;
  typedef struct packed {
    logic       Valid;
    logic       SoP;
    logic       EoP;
    logic [7:0] Data;
    logic [7:0] Length;
    logic [7:0] Source;
    logic [7:0] Destination;
  } UART_PACKET;

  UART_PACKET opTxStream;
  logic       ipTxReady;

  modport master (output opTxStream, input ipTxReady);
  modport slave  (input opTxStream, output ipTxReady);
endinterface
`default_nettype wire

// File: rtl/qam_stream_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qam_stream_packer : nibbles -> 16-bit words -> FWFT FIFO -> packets|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module qam_stream_packer #(
  parameter int         PACKET_WORDS = 4,
  parameter int         IDLE_TIMEOUT = 2267,
  parameter logic [7:0] SOURCE_ID    = 8'h20,
  parameter logic [7:0] DEST_ID      = 8'hAA
) (
  input  wire logic        ipClk,
  input  wire logic        nReset,
  input  wire logic [3:0]  ipQAMBlock,
  input  wire logic        ipQAMBlockValid,
  input  wire logic        ipSync,
  qam_stream_packer_if.master tx,
  output logic [12:0]      opFIFO_Size,
  output logic             opOverflow
);
  localparam int              c_DEPTH    = 4096;
  localparam int              c_IW       = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [c_IW-1:0] c_IDLE_MAX = c_IW'(IDLE_TIMEOUT);
  localparam logic [12:0]     c_PKT      = 13'(PACKET_WORDS);
  localparam logic [12:0]     c_FULL     = 13'(c_DEPTH);

  typedef enum logic [1:0] {TxIdle = 2'd0, TxLow = 2'd1, TxHigh = 2'd2} tx_state_t;

  logic [1:0]      r_nib_cnt;
  logic [11:0]     r_hold;
  logic [15:0]     r_word;
  logic            r_wr;
  logic [c_IW-1:0] r_idle;
  logic [15:0]     r_mem [c_DEPTH];
  logic [11:0]     r_wr_ptr, r_rd_ptr;
  logic [12:0]     r_count;
  logic            r_ovf;
  tx_state_t       r_state, w_state_nxt;
  logic [6:0]      r_n;
  logic            r_first;
  logic [7:0]      r_len;

  logic            w_full, w_push, w_pop, w_load, w_start;
  logic            w_valid, w_sop, w_eop;
  logic [7:0]      w_data;
  logic [6:0]      w_take;
  logic [15:0]     w_head;

  // A sync drops any held nibbles; a symbol in the same cycle becomes nibble 0.
  always_ff @(posedge ipClk) begin
    if (nReset) begin
      r_nib_cnt <= 2'd0;
      r_hold    <= 12'h0;
      r_word    <= 16'h0;
      r_wr      <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      if (ipSync) begin
        r_hold    <= ipQAMBlockValid ? {8'h0, ipQAMBlock} : 12'h0;
        r_nib_cnt <= ipQAMBlockValid ? 2'd1 : 2'd0;
      end else if (ipQAMBlockValid) begin
        case (r_nib_cnt)
          2'd0:    r_hold[3:0]  <= ipQAMBlock;
          2'd1:    r_hold[7:4]  <= ipQAMBlock;
          2'd2:    r_hold[11:8] <= ipQAMBlock;
          default: begin
            r_word <= {ipQAMBlock, r_hold};
            r_wr   <= 1'b1;
          end
        endcase
        r_nib_cnt <= r_nib_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge ipClk) begin
    if (nReset || ipQAMBlockValid) r_idle <= '0;
    else if (r_idle != c_IDLE_MAX) r_idle <= r_idle + 1'b1;
  end

  assign w_full = (r_count == c_FULL);
  assign w_push = r_wr && !w_full;
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge ipClk) begin
    if (w_push && !nReset) r_mem[r_wr_ptr] <= r_word;
  end

  always_ff @(posedge ipClk) begin
    if (nReset) begin
      r_wr_ptr <= 12'd0;
      r_rd_ptr <= 12'd0;
      r_count  <= 13'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 12'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 12'd1;
      if (r_wr && w_full) r_ovf <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 13'd1;
        2'b01:   r_count <= r_count - 13'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_start = (r_count >= c_PKT) || ((r_count != 13'd0) && (r_idle == c_IDLE_MAX));
  assign w_take  = (r_count >= c_PKT) ? 7'(PACKET_WORDS) : r_count[6:0];

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_sop       = 1'b0;
    w_eop       = 1'b0;
    w_data      = 8'h0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      TxIdle: if (w_start) begin
        w_state_nxt = TxLow;
        w_load      = 1'b1;
      end
      TxLow: if (tx.ipTxReady) begin
        w_valid     = 1'b1;
        w_sop       = r_first;
        w_data      = w_head[7:0];
        w_state_nxt = TxHigh;
      end
      TxHigh: if (tx.ipTxReady) begin
        w_valid     = 1'b1;
        w_eop       = (r_n == 7'd1);
        w_data      = w_head[15:8];
        w_pop       = 1'b1;
        w_state_nxt = (r_n == 7'd1) ? TxIdle : TxLow;
      end
      default: w_state_nxt = TxIdle;
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (nReset) begin
      r_state <= TxIdle;
      r_n     <= 7'd0;
      r_first <= 1'b0;
      r_len   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_n     <= w_take;
        r_first <= 1'b1;
        r_len   <= {w_take, 1'b0};
      end else begin
        if (w_pop)   r_n     <= r_n - 7'd1;
        if (w_valid) r_first <= 1'b0;
      end
    end
  end

  // Outputs are forced quiet for the whole time reset is held.
  always_comb begin
    tx.opTxStream             = '0;
    tx.opTxStream.Valid       = w_valid & ~nReset;
    tx.opTxStream.SoP         = w_sop & ~nReset;
    tx.opTxStream.EoP         = w_eop & ~nReset;
    tx.opTxStream.Data        = nReset ? 8'h0 : w_data;
    tx.opTxStream.Length      = nReset ? 8'h0 : r_len;
    tx.opTxStream.Source      = SOURCE_ID;
    tx.opTxStream.Destination = DEST_ID;
  end

  assign opFIFO_Size = r_count;
  assign opOverflow  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_qam_stream_packer.sv
`default_nettype none
// tb_qam_stream_packer: random and directed stimulus checked against a
// word-queue model of the packer's byte stream.
module tb_qam_stream_packer;
  localparam int PW = 4;
  localparam int IT = 50;

  logic        ipClk = 1'b0;
  logic        nReset = 1'b1;
  logic [3:0]  ipQAMBlock = 4'h0;
  logic        ipQAMBlockValid = 1'b0;
  logic        ipSync = 1'b0;
  logic [12:0] opFIFO_Size;
  logic        opOverflow;

  qam_stream_packer_if txif();

  qam_stream_packer #(.PACKET_WORDS(PW), .IDLE_TIMEOUT(IT),
                      .SOURCE_ID(8'h20), .DEST_ID(8'hAA)) dut (
    .ipClk(ipClk), .nReset(nReset), .ipQAMBlock(ipQAMBlock),
    .ipQAMBlockValid(ipQAMBlockValid), .ipSync(ipSync), .tx(txif),
    .opFIFO_Size(opFIFO_Size), .opOverflow(opOverflow));

  always #5 ipClk = ~ipClk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: nibbles since the last sync/word, and words still owed on the stream.
  logic [3:0]  part[$];
  logic [15:0] exp_q[$];

  function automatic void model_sym(input logic v, input logic [3:0] n, input logic s);
    if (s) part.delete();
    if (v) begin
      part.push_back(n);
      if (part.size() == 4) begin
        exp_q.push_back({part[3], part[2], part[1], part[0]});
        part.delete();
      end
    end
  endfunction

  int cyc = 0;
  always @(posedge ipClk) cyc <= cyc + 1;

  int ready_mode = 0;
  initial begin
    txif.ipTxReady = 1'b0;
    forever begin
      @(posedge ipClk); #1;
      case (ready_mode)
        1:       txif.ipTxReady = 1'b1;
        2:       txif.ipTxReady = ~txif.ipTxReady;
        3:       txif.ipTxReady = ($urandom_range(0, 9) < 7);
        default: txif.ipTxReady = 1'b0;
      endcase
    end
  end

  bit         mon_en = 1'b0;
  bit         half = 1'b0;
  int         byte_idx = 0;
  int         pkt_len = 0;
  int         byte_total = 0;
  int         pkt_count = 0;
  int         sop_cyc = 0;
  logic [7:0] byte_log[$];
  int         len_log[$];
  logic [7:0] exp_b;

  always @(negedge ipClk) begin
    if (mon_en && !nReset) begin
      if (txif.opTxStream.Valid) begin
        chk("valid_needs_ready", txif.ipTxReady, 1);
        chk("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_b = half ? exp_q[0][15:8] : exp_q[0][7:0];
          chk("data", txif.opTxStream.Data, exp_b);
          if (half) void'(exp_q.pop_front());
        end
        half = ~half;
        chk("sop", txif.opTxStream.SoP, byte_idx == 0);
        if (byte_idx == 0) begin
          pkt_len = txif.opTxStream.Length;
          sop_cyc = cyc;
          len_log.push_back(pkt_len);
          chk("len_range", (pkt_len >= 2 && pkt_len <= 2*PW && pkt_len % 2 == 0), 1);
        end
        chk("len_const", txif.opTxStream.Length, pkt_len);
        chk("eop", txif.opTxStream.EoP, byte_idx == pkt_len - 1);
        chk("src", txif.opTxStream.Source, 8'h20);
        chk("dst", txif.opTxStream.Destination, 8'hAA);
        byte_log.push_back(txif.opTxStream.Data);
        byte_total++;
        if (byte_idx >= pkt_len - 1) begin
          byte_idx = 0;
          pkt_count++;
        end else byte_idx++;
      end else begin
        chk("quiet_sop_eop", {txif.opTxStream.SoP, txif.opTxStream.EoP}, 0);
      end
    end
  end

  task automatic tick(input logic v, input logic [3:0] n, input logic s);
    ipQAMBlockValid = v;
    ipQAMBlock      = n;
    ipSync          = s;
    model_sym(v, n, s);
    @(posedge ipClk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 1'b0);
  endtask

  task automatic send_word(input logic [15:0] w);
    tick(1'b1, w[3:0], 1'b0);
    tick(1'b1, w[7:4], 1'b0);
    tick(1'b1, w[11:8], 1'b0);
    tick(1'b1, w[15:12], 1'b0);
  endtask

  task automatic do_reset();
    mon_en     = 1'b0;
    ready_mode = 0;
    nReset     = 1'b1;
    ipQAMBlockValid = 1'b0;
    ipSync     = 1'b0;
    repeat (2) @(posedge ipClk);
    @(negedge ipClk);
    chk("rst_valid", txif.opTxStream.Valid, 0);
    chk("rst_sop_eop", {txif.opTxStream.SoP, txif.opTxStream.EoP}, 0);
    chk("rst_data", txif.opTxStream.Data, 0);
    chk("rst_length", txif.opTxStream.Length, 0);
    chk("rst_src", txif.opTxStream.Source, 8'h20);
    chk("rst_dst", txif.opTxStream.Destination, 8'hAA);
    chk("rst_size", opFIFO_Size, 0);
    chk("rst_ovf", opOverflow, 0);
    part.delete(); exp_q.delete(); byte_log.delete(); len_log.delete();
    half = 1'b0; byte_idx = 0; pkt_len = 0; byte_total = 0; pkt_count = 0;
    @(posedge ipClk); #1;
    nReset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain(input string nm, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && opFIFO_Size == 0 && byte_idx == 0) begin
        done = 1'b1;
        break;
      end
      tick(1'b0, 4'h0, 1'b0);
    end
    chk(nm, done, 1);
    idle(IT + 10);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_sym;
    bit seen;
    @(posedge ipClk); #1;

    // Full packet of 16'h1234 words
    do_reset();
    ready_mode = 1;
    for (int w = 0; w < 4; w++) begin
      tick(1'b1, 4'h4, 1'b0); tick(1'b1, 4'h3, 1'b0);
      tick(1'b1, 4'h2, 1'b0); tick(1'b1, 4'h1, 1'b0);
    end
    drain("drain_full", 200);
    chk("full_pkts", pkt_count, 1);
    chk("full_len", len_log[0], 8);
    chk("full_b0", byte_log[0], 8'h34);
    chk("full_b1", byte_log[1], 8'h12);
    chk("full_b7", byte_log[7], 8'h12);

    // Idle flush of a two-word partial packet
    do_reset();
    ready_mode = 1;
    send_word(16'hBEEF);
    send_word(16'h0001);
    last_sym = cyc;
    drain("drain_flush", IT + 100);
    chk("flush_len", len_log[0], 4);
    chk("flush_bytes", {byte_log[0], byte_log[1], byte_log[2], byte_log[3]}, 32'hEFBE0100);
    chk("flush_delay", (sop_cyc - last_sym >= IT) && (sop_cyc - last_sym <= IT + 4), 1);

    // Back-pressure toggling every cycle
    do_reset();
    ready_mode = 2;
    send_word(16'hA5C3); send_word(16'h0F1E); send_word(16'h7788); send_word(16'h9001);
    drain("drain_toggle", 300);
    chk("toggle_len", len_log[0], 8);
    chk("toggle_bytes", byte_total, 8);

    // Sync discards partial nibbles
    do_reset();
    ready_mode = 1;
    tick(1'b1, 4'h1, 1'b0); tick(1'b1, 4'h2, 1'b0); tick(1'b1, 4'h3, 1'b0);
    tick(1'b0, 4'h0, 1'b1);
    tick(1'b1, 4'hA, 1'b0); tick(1'b1, 4'hB, 1'b0);
    tick(1'b1, 4'hC, 1'b0); tick(1'b1, 4'hD, 1'b0);
    chk("sync_model_q", exp_q.size(), 1);
    if (exp_q.size() > 0) chk("sync_model_word", exp_q[0], 16'hDCBA);
    drain("drain_sync", IT + 100);
    chk("sync_len", len_log[0], 2);
    chk("sync_bytes", {byte_log[0], byte_log[1]}, 16'hBADC);

    // Random symbols, syncs and back-pressure
    do_reset();
    ready_mode = 3;
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 9) < 6, 4'($urandom), $urandom_range(0, 99) < 3);
    drain("drain_random", 3000);

    // Reset in the middle of a Length=8 packet
    do_reset();
    ready_mode = 0;
    send_word(16'h1111); send_word(16'h2222); send_word(16'h3333); send_word(16'h4444);
    idle(3);
    ready_mode = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ipClk); #1;
      if (byte_total >= 3) begin seen = 1'b1; break; end
    end
    chk("midrst_three_bytes", seen, 1);
    mon_en = 1'b0;
    @(posedge ipClk); #1;
    nReset = 1'b1;
    @(negedge ipClk);
    chk("midrst_valid_k1", txif.opTxStream.Valid, 0);
    chk("midrst_eop_k1", txif.opTxStream.EoP, 0);
    @(negedge ipClk);
    chk("midrst_valid_k2", txif.opTxStream.Valid, 0);
    chk("midrst_size", opFIFO_Size, 0);
    do_reset();
    ready_mode = 1;
    idle(IT + 20);
    chk("midrst_nothing_after", byte_total, 0);

    // Overflow: fill 4096 words without draining, then one more
    do_reset();
    ready_mode = 0;
    for (int i = 0; i < 4097; i++) send_word(16'(i * 7 + 3));
    idle(4);
    chk("ovf_size", opFIFO_Size, 4096);
    chk("ovf_flag", opOverflow, 1);
    void'(exp_q.pop_back());
    ready_mode = 1;
    drain("drain_ovf", 12000);
    chk("ovf_bytes", byte_total, 8192);
    chk("ovf_sticky", opOverflow, 1);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
